// File: rtl/fpadd_pkg.sv
// Shared definitions for the floating-point adder arbiter: FSM encoding,
// default widths and the watchdog counter width.
package fpadd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } fpadd_state_t;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_W       = 8;
    localparam int DEF_MAX_CYC = 16;

    // Wide enough for any practical MAX_CYC (up to 256).
    localparam int TMO_CNT_W   = 8;

endpackage

// File: rtl/fpadd_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer,
// searching upward and wrapping modulo NREQ.
module fpadd_rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [IDX_W-1:0] o_sel,
    output logic             o_any
);

    always_comb begin
        o_sel = '0;
        o_any = |i_req;
        // Scan from the farthest offset down so the nearest hit overwrites last.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (i_req[(int'(i_ptr) + k) % NREQ]) begin
                o_sel = IDX_W'((int'(i_ptr) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/fpadd_arbiter.sv
// Round-robin sharing of one floating-point adder core among NREQ clients.
// Optional WAIT watchdog enabled by defining FPADD_ARB_TIMEOUT_EN.
module fpadd_arbiter
    import fpadd_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int W       = DEF_W,
    parameter int MAX_CYC = DEF_MAX_CYC
) (
    input  logic                     clk,
    input  logic                     clr_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*W-1:0]        op_a,
    input  logic [NREQ*W-1:0]        op_b,
    output logic [NREQ-1:0]          grant,
    output logic                     add_start,
    output logic [W-1:0]             add_a,
    output logic [W-1:0]             add_b,
    input  logic                     add_done,
    input  logic [W-1:0]             add_sum,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [W-1:0]             rsp_sum,
    output logic                     rsp_err,
    output logic                     busy
);

    localparam int IDX_W = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || MAX_CYC < 2) begin : g_bad_param
        $error("fpadd_arbiter: NREQ must be 2..8 and MAX_CYC at least 2");
    end

    fpadd_state_t     r_state;
    fpadd_state_t     w_state_next;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_sel;
    logic [W-1:0]     r_add_a;
    logic [W-1:0]     r_add_b;
    logic [W-1:0]     r_rsp_sum;
    logic [IDX_W-1:0] w_sel;
    logic             w_any;
    logic             w_load_job;
    logic             w_load_rsp;
    logic             w_accept;
    logic [NREQ-1:0]  w_grant;

    fpadd_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_sel (w_sel),
        .o_any (w_any)
    );

`ifdef FPADD_ARB_TIMEOUT_EN
    logic [TMO_CNT_W-1:0] r_cnt;
    logic                 r_rsp_err;
    logic                 w_tmo;
`endif

    always_comb begin
        w_state_next = r_state;
        w_load_job   = 1'b0;
        w_load_rsp   = 1'b0;
        w_accept     = 1'b0;
`ifdef FPADD_ARB_TIMEOUT_EN
        w_tmo        = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_load_job   = 1'b1;
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (add_done) begin
                    w_load_rsp   = 1'b1;
                    w_state_next = ST_RESP;
                end
`ifdef FPADD_ARB_TIMEOUT_EN
                // Expiry cycle chosen so RESP lands MAX_CYC cycles after add_start.
                else if (r_cnt == TMO_CNT_W'(MAX_CYC - 2)) begin
                    w_tmo        = 1'b1;
                    w_state_next = ST_RESP;
                end
`endif
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_grant = '0;
        if (r_state == ST_ISSUE) begin
            w_grant[r_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_sel     <= '0;
            r_add_a   <= '0;
            r_add_b   <= '0;
            r_rsp_sum <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load_job) begin
                r_sel   <= w_sel;
                r_add_a <= op_a[w_sel*W +: W];
                r_add_b <= op_b[w_sel*W +: W];
            end
            if (w_load_rsp) begin
                r_rsp_sum <= add_sum;
            end
`ifdef FPADD_ARB_TIMEOUT_EN
            if (w_tmo) begin
                r_rsp_sum <= '0;
            end
`endif
            if (w_accept) begin
                r_ptr <= (r_sel == IDX_W'(NREQ - 1)) ? '0 : r_sel + 1'b1;
            end
        end
    end

`ifdef FPADD_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_cnt     <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            if (r_state == ST_ISSUE) begin
                r_cnt <= '0;
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_load_rsp) begin
                r_rsp_err <= 1'b0;
            end else if (w_tmo) begin
                r_rsp_err <= 1'b1;
            end
        end
    end

    assign rsp_err = r_rsp_err;
`else
    assign rsp_err = 1'b0;
`endif

    assign grant     = w_grant;
    assign add_start = (r_state == ST_ISSUE);
    assign add_a     = r_add_a;
    assign add_b     = r_add_b;
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_id    = r_sel;
    assign rsp_sum   = r_rsp_sum;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fpadd_arbiter.sv
// Directed self-checking bench for fpadd_arbiter; the bench plays the adder core
// and the response consumer. Timeout checks follow FPADD_ARB_TIMEOUT_EN.
module tb_fpadd_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 8;

    logic             clk = 1'b0;
    logic             clr_n;
    logic [NREQ-1:0]  req;
    logic [NREQ*W-1:0] op_a;
    logic [NREQ*W-1:0] op_b;
    logic [NREQ-1:0]  grant;
    logic             add_start;
    logic [W-1:0]     add_a;
    logic [W-1:0]     add_b;
    logic             add_done;
    logic [W-1:0]     add_sum;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_id;
    logic [W-1:0]     rsp_sum;
    logic             rsp_err;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    fpadd_arbiter #(
        .NREQ    (NREQ),
        .W       (W),
        .MAX_CYC (16)
    ) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .req       (req),
        .op_a      (op_a),
        .op_b      (op_b),
        .grant     (grant),
        .add_start (add_start),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_done  (add_done),
        .add_sum   (add_sum),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench time limit");
    end

    task automatic test_reset();
        clr_n = 1'b0; req = '0; op_a = '0; op_b = '0;
        add_done = 1'b0; add_sum = '0; rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({grant, add_start, busy, rsp_valid, rsp_err} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: grant=%b start=%b busy=%b valid=%b err=%b, required all 0",
                     grant, add_start, busy, rsp_valid, rsp_err);
        end
        n_checks++;
        if ({add_a, add_b, rsp_sum, rsp_id} !== 26'b0) begin
            n_fail++;
            $display("FAIL reset_data: add_a=%h add_b=%h rsp_sum=%h rsp_id=%0d, required 0",
                     add_a, add_b, rsp_sum, rsp_id);
        end
        clr_n = 1'b1;
        $display("reset: outputs checked after reset");
    endtask

    task automatic test_single_job();
        req  = 4'b0001;
        op_a = {8'h00, 8'h00, 8'h00, 8'h3C};
        op_b = {8'h00, 8'h00, 8'h00, 8'h3C};
        @(negedge clk);
        n_checks++;
        if (grant !== 4'b0001 || add_start !== 1'b1) begin
            n_fail++;
            $display("FAIL single_grant: grant=%b start=%b, required 0001/1", grant, add_start);
        end
        n_checks++;
        if (add_a !== 8'h3C || add_b !== 8'h3C) begin
            n_fail++;
            $display("FAIL single_ops: add_a=%h add_b=%h, required 3c/3c", add_a, add_b);
        end
        req = '0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b0 || busy !== 1'b1 || add_start !== 1'b0) begin
                n_fail++;
                $display("FAIL single_wait%0d: valid=%b busy=%b start=%b, required 0/1/0",
                         i, rsp_valid, busy, add_start);
            end
        end
        @(negedge clk);
        add_done = 1'b1; add_sum = 8'h44;
        @(negedge clk);
        add_done = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 8'h44 || rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL single_rsp: valid=%b id=%0d sum=%h err=%b, required 1/0/44/0",
                     rsp_valid, rsp_id, rsp_sum, rsp_err);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: busy=%b valid=%b, required 0/0", busy, rsp_valid);
        end
        $display("single: id=%0d sum=%h", rsp_id, rsp_sum);
    endtask

    task automatic test_round_robin();
        int         exp_id [5];
        logic [7:0] exp_op [4];
        int         t;
        exp_id = '{0, 1, 2, 3, 0};
        exp_op = '{8'h11, 8'h22, 8'h33, 8'h44};
        clr_n = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
        op_a = {8'h44, 8'h33, 8'h22, 8'h11};
        op_b = {8'h04, 8'h03, 8'h02, 8'h01};
        req  = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            t = 0;
            while (grant === 4'b0000 && t < 8) begin
                @(negedge clk);
                t++;
            end
            n_checks++;
            if (grant !== (4'b0001 << exp_id[i]) || add_a !== exp_op[exp_id[i]]) begin
                n_fail++;
                $display("FAIL rr_grant%0d: grant=%b add_a=%h, required %b/%h",
                         i, grant, add_a, 4'b0001 << exp_id[i], exp_op[exp_id[i]]);
            end
            if (i == 4) req = '0;
            @(negedge clk);
            add_done = 1'b1; add_sum = 8'hA0 + 8'(i);
            @(negedge clk);
            add_done = 1'b0;
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_id[i]) || rsp_sum !== 8'hA0 + 8'(i)) begin
                n_fail++;
                $display("FAIL rr_rsp%0d: valid=%b id=%0d sum=%h, required 1/%0d/%h",
                         i, rsp_valid, rsp_id, rsp_sum, exp_id[i], 8'hA0 + 8'(i));
            end
            $display("rr job %0d: id=%0d sum=%h", i, rsp_id, rsp_sum);
        end
        @(negedge clk);
    endtask

    // Leaves the block in ISSUE for a client-2 job; test_reset_mid picks up from there.
    task automatic test_backpressure();
        req = 4'b0010; rsp_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (grant !== 4'b0010) begin
            n_fail++;
            $display("FAIL bp_grant: grant=%b, required 0010", grant);
        end
        req = '0;
        @(negedge clk);
        add_done = 1'b1; add_sum = 8'h5A;
        @(negedge clk);
        add_done = 1'b0;
        req = 4'b1101;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 8'h5A ||
                busy !== 1'b1 || grant !== 4'b0000) begin
                n_fail++;
                $display("FAIL bp_hold%0d: valid=%b id=%0d sum=%h busy=%b grant=%b, required 1/1/5a/1/0000",
                         i, rsp_valid, rsp_id, rsp_sum, busy, grant);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_sum !== 8'h5A) begin
            n_fail++;
            $display("FAIL bp_last: valid=%b sum=%h, required 1/5a", rsp_valid, rsp_sum);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_idle: busy=%b valid=%b, required 0/0", busy, rsp_valid);
        end
        @(negedge clk);
        n_checks++;
        if (grant !== 4'b0100) begin
            n_fail++;
            $display("FAIL bp_next_grant: grant=%b, required 0100", grant);
        end
        req = '0;
        $display("backpressure: held response accepted, next grant=%b", grant);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        clr_n = 1'b0;
        #1;
        n_checks++;
        if ({grant, add_start, busy, rsp_valid, rsp_err} !== 8'b0 ||
            {add_a, add_b, rsp_sum, rsp_id} !== 26'b0) begin
            n_fail++;
            $display("FAIL mid_reset: grant=%b start=%b busy=%b valid=%b a=%h b=%h sum=%h id=%0d, required 0",
                     grant, add_start, busy, rsp_valid, add_a, add_b, rsp_sum, rsp_id);
        end
        @(negedge clk);
        clr_n = 1'b1;
        req   = 4'b0101;
        @(negedge clk);
        n_checks++;
        if (grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL mid_ptr: grant=%b, required 0001", grant);
        end
        req = '0;
        @(negedge clk);
        add_done = 1'b1; add_sum = 8'h77;
        @(negedge clk);
        add_done = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 8'h77) begin
            n_fail++;
            $display("FAIL mid_rsp: valid=%b id=%0d sum=%h, required 1/0/77", rsp_valid, rsp_id, rsp_sum);
        end
        @(negedge clk);
        $display("reset_mid: job dropped, restart grant to client 0");
    endtask

    task automatic test_done_ignored();
        add_done = 1'b1; add_sum = 8'hEE;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ign_idle: busy=%b valid=%b, required 0/0", busy, rsp_valid);
        end
        req = 4'b0010;
        @(negedge clk);
        n_checks++;
        if (grant !== 4'b0010) begin
            n_fail++;
            $display("FAIL ign_grant: grant=%b, required 0010", grant);
        end
        req = '0;
        @(negedge clk);
        add_done = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ign_issue: valid=%b busy=%b, required 0/1", rsp_valid, busy);
        end
        add_done = 1'b1; add_sum = 8'h12;
        @(negedge clk);
        add_done = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 8'h12) begin
            n_fail++;
            $display("FAIL ign_rsp: valid=%b id=%0d sum=%h, required 1/1/12", rsp_valid, rsp_id, rsp_sum);
        end
        @(negedge clk);
        $display("done_ignored: id=%0d sum=%h", rsp_id, rsp_sum);
    endtask

    task automatic test_timeout();
        int n;
        req = 4'b0100;
        @(negedge clk);
        n_checks++;
        if (grant !== 4'b0100 || add_start !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_grant: grant=%b start=%b, required 0100/1", grant, add_start);
        end
        req = '0;
`ifdef FPADD_ARB_TIMEOUT_EN
        n = 0;
        while (rsp_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n != 16 || rsp_err !== 1'b1 || rsp_sum !== 8'h00) begin
            n_fail++;
            $display("FAIL tmo_expire: cycles=%0d err=%b sum=%h, required 16/1/00", n, rsp_err, rsp_sum);
        end
        @(negedge clk);
`else
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy === 1'b1 && rsp_valid === 1'b0) n++;
        end
        n_checks++;
        if (n != 30) begin
            n_fail++;
            $display("FAIL tmo_none: waiting cycles=%0d, required 30", n);
        end
        clr_n = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
`endif
        $display("timeout: job on client 2 observed for %0d cycles", n);
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_done_ignored();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
